// File: rtl/flit_serializer_2_if.sv
// Packet-in, flit-out and credit-return bundle of the 2-flit serializer.
// The master side is the upstream packetizer. The slave side is the serializer.
interface flit_serializer_2_if #(
    parameter int WIDTH_OUT        = 36,
    parameter int VC_ADDRESS_WIDTH = 1
);
    localparam int FLIT_WIDTH = WIDTH_OUT / 2;

    logic [WIDTH_OUT-1:0]        pkt_in;
    logic                        pkt_valid_in;
    logic                        pkt_ready_out;
    logic [FLIT_WIDTH-1:0]       flit_out;
    logic                        flit_valid_out;
    logic                        credit_valid_in;
    logic [VC_ADDRESS_WIDTH-1:0] credit_vc_in;

    modport master (
        output pkt_in,
        output pkt_valid_in,
        output credit_valid_in,
        output credit_vc_in,
        input  pkt_ready_out,
        input  flit_out,
        input  flit_valid_out
    );

    modport slave (
        input  pkt_in,
        input  pkt_valid_in,
        input  credit_valid_in,
        input  credit_vc_in,
        output pkt_ready_out,
        output flit_out,
        output flit_valid_out
    );
endinterface

// File: rtl/flit_serializer_2.sv
// 2-flit packet serializer with per-VC credit flow control toward a NoC router.
// Defining FLIT_SERIALIZER_STATS_EN adds packet, flit and stall counters.
module flit_serializer_2 #(
    parameter int WIDTH_OUT        = 36,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int CREDIT_DEPTH     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    flit_serializer_2_if.slave  bus
`ifdef FLIT_SERIALIZER_STATS_EN
    ,
    output logic [31:0]         pkt_count_out,
    output logic [31:0]         flit_count_out,
    output logic [31:0]         stall_count_out
`endif
);
    localparam int FLIT_WIDTH   = WIDTH_OUT / 2;
    localparam int NUM_VC       = 2 ** VC_ADDRESS_WIDTH;
    localparam int CREDIT_WIDTH = $clog2(CREDIT_DEPTH + 1);
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX =
        CREDIT_WIDTH'(CREDIT_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        TAIL
    } state_t;

    state_t                      state;
    logic [WIDTH_OUT-1:0]        pkt_q;
    logic [VC_ADDRESS_WIDTH-1:0] vc_q;
    logic [FLIT_WIDTH-1:0]       flit_q;
    logic                        flit_valid_q;
    logic [CREDIT_WIDTH-1:0]     credit      [NUM_VC];
    logic [CREDIT_WIDTH-1:0]     credit_next [NUM_VC];

    logic [FLIT_WIDTH-1:0]       head_flit;
    logic [FLIT_WIDTH-1:0]       tail_flit;
    logic [FLIT_WIDTH-1:0]       cur_flit;
    logic [VC_ADDRESS_WIDTH-1:0] in_vc;
    logic                        two_flit;
    logic                        has_credit;
    logic                        busy;
    logic                        emit;
    logic                        last;
    logic                        ready;
    logic                        accept;
    logic                        load;

    assign head_flit  = pkt_q[WIDTH_OUT-1 -: FLIT_WIDTH];
    assign tail_flit  = pkt_q[FLIT_WIDTH-1:0];
    assign two_flit   = tail_flit[FLIT_WIDTH-1];
    assign in_vc      = bus.pkt_in[WIDTH_OUT-4 -: VC_ADDRESS_WIDTH];
    assign has_credit = (credit[vc_q] != '0);
    assign busy       = (state == HEAD) || (state == TAIL);
    assign emit       = busy && has_credit;
    assign last       = (state == TAIL) || !two_flit;
    assign cur_flit   = (state == TAIL) ? tail_flit : head_flit;

    // Ready opens only on the cycle that frees the holding register.
    assign ready = rst_n &&
                   ((state == IDLE) ||
                    ((state == TAIL) && has_credit) ||
                    ((state == HEAD) && !two_flit && has_credit));

    assign accept = bus.pkt_valid_in && ready;
    assign load   = accept && bus.pkt_in[WIDTH_OUT-1];

    assign bus.pkt_ready_out  = ready;
    assign bus.flit_out       = flit_q;
    assign bus.flit_valid_out = flit_valid_q;

    // A same-edge return and spend on one VC cancel out.
    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            credit_next[i] = credit[i];
            if (emit && (vc_q == VC_ADDRESS_WIDTH'(i)) &&
                !(bus.credit_valid_in &&
                  (bus.credit_vc_in == VC_ADDRESS_WIDTH'(i)))) begin
                credit_next[i] = credit[i] - 1'b1;
            end else if (!(emit && (vc_q == VC_ADDRESS_WIDTH'(i))) &&
                         bus.credit_valid_in &&
                         (bus.credit_vc_in == VC_ADDRESS_WIDTH'(i)) &&
                         (credit[i] != CREDIT_MAX)) begin
                credit_next[i] = credit[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pkt_q        <= '0;
            vc_q         <= '0;
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
            for (int i = 0; i < NUM_VC; i++) begin
                credit[i] <= CREDIT_MAX;
            end
        end else begin
            flit_valid_q <= emit;
            flit_q       <= emit ? cur_flit : '0;
            for (int i = 0; i < NUM_VC; i++) begin
                credit[i] <= credit_next[i];
            end
            if (load) begin
                pkt_q <= bus.pkt_in;
                vc_q  <= in_vc;
            end
            // A packet whose head flit is invalid is dropped on acceptance.
            unique case (state)
                IDLE: begin
                    if (load) state <= HEAD;
                end
                HEAD: begin
                    if (emit) begin
                        if (!last)     state <= TAIL;
                        else if (load) state <= HEAD;
                        else           state <= IDLE;
                    end
                end
                TAIL: begin
                    if (emit) state <= load ? HEAD : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FLIT_SERIALIZER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_out   <= '0;
            flit_count_out  <= '0;
            stall_count_out <= '0;
        end else begin
            if (accept)              pkt_count_out   <= pkt_count_out + 1'b1;
            if (emit)                flit_count_out  <= flit_count_out + 1'b1;
            if (busy && !has_credit) stall_count_out <= stall_count_out + 1'b1;
        end
    end
`endif

endmodule
